// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-bit shift sequencer.
package shift_pkg;

  typedef enum logic [1:0] {
    LOGICAL = 2'b00,
    ARITH   = 2'b01,
    ROTATE  = 2'b10,
    FILL    = 2'b11
  } shift_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shift_state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_step_reg.sv
// Loadable working register that moves its contents by one bit per enabled
// clock. The bit leaving the register on the current step is exposed so the
// controller can record the carry on the same edge.
module shift_step_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             step_i,
  input  logic             dir_i,
  input  shift_mode_e      mode_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] data_o,
  output logic             out_bit_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             in_bit;

  // Work out the bit entering the vacated end and the bit falling off the other end.
  always_comb begin
    in_bit    = 1'b0;
    out_bit_o = (dir_i == DIR_RIGHT) ? data_q[0] : data_q[WIDTH-1];
    case (mode_i)
      LOGICAL: in_bit = 1'b0;
      ARITH:   in_bit = (dir_i == DIR_RIGHT) ? data_q[WIDTH-1] : 1'b0;
      ROTATE:  in_bit = (dir_i == DIR_RIGHT) ? data_q[0] : data_q[WIDTH-1];
      FILL:    in_bit = fill_i;
      default: in_bit = 1'b0;
    endcase
    if (dir_i == DIR_RIGHT) begin
      data_d = {in_bit, data_q[WIDTH-1:1]};
    end else begin
      data_d = {data_q[WIDTH-2:0], in_bit};
    end
  end

  // A load takes priority over a step; otherwise the register holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_data_i;
    end else if (step_i) begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-bit shift sequencer: takes one command, performs it as a series of
// 1-bit steps, and presents the result until the consumer takes it.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic             cmd_dir,
  input  logic [1:0]       cmd_mode,
  input  logic             cmd_fill,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             busy
);

  localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] CNT_ONE   = AMT_W'(1);

  shift_state_e     state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             dir_q, dir_d;
  shift_mode_e      mode_q, mode_d;
  logic             fill_q, fill_d;
  logic             load;
  logic             step;
  logic             out_bit;
  logic [AMT_W-1:0] amt_clamped;

  assign amt_clamped = (cmd_amt > WIDTH_AMT) ? WIDTH_AMT : cmd_amt;

  shift_step_reg #(
    .WIDTH(WIDTH)
  ) u_step (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .load_data_i(cmd_data),
    .step_i     (step),
    .dir_i      (dir_q),
    .mode_i     (mode_q),
    .fill_i     (fill_q),
    .data_o     (res_data),
    .out_bit_o  (out_bit)
  );

  // Next-state, counter and step control. A zero-amount command still spends
  // one cycle in SHIFT (without stepping) so every command takes at least one
  // cycle before its result appears.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          load    = 1'b1;
          dir_d   = cmd_dir;
          mode_d  = shift_mode_e'(cmd_mode);
          fill_d  = cmd_fill;
          cnt_d   = amt_clamped;
          carry_d = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          step    = 1'b1;
          carry_d = out_bit;
          cnt_d   = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, carry and latched command attributes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      dir_q   <= DIR_LEFT;
      mode_q  <= LOGICAL;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT) || (state_q == DONE);
  assign res_carry = carry_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed cases with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = 8'h00;
  logic [3:0] cmd_amt = 4'd0;
  logic       cmd_dir = 1'b0;
  logic [1:0] cmd_mode = 2'b00;
  logic       cmd_fill = 1'b0;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_carry;
  logic       busy;

  int total = 0;
  int bad = 0;

  // Model state: whether a command is in flight, cycles left before its result
  // appears, and the expected result.
  bit         mdl_pending = 1'b0;
  int         mdl_left = 0;
  logic [7:0] mdl_data = 8'h00;
  logic       mdl_carry = 1'b0;

  shift_seq_ctrl #(
    .WIDTH(8),
    .AMT_W(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_data (cmd_data),
    .cmd_amt  (cmd_amt),
    .cmd_dir  (cmd_dir),
    .cmd_mode (cmd_mode),
    .cmd_fill (cmd_fill),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_carry(res_carry),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Whole-operation result computed directly from the shift definitions.
  function automatic logic [8:0] refShift(input logic [7:0] d, input int amt, input bit dir,
                                          input logic [1:0] mode, input bit fill);
    int n = (amt > 8) ? 8 : amt;
    int v = d;
    int r;
    bit c;
    if (n == 0) return {1'b0, d};
    if (!dir) begin
      c = d[8-n];
      case (mode)
        2'b10:   r = (((v << 8) | v) << n) >> 8;
        2'b11:   r = (v << n) | (fill ? ((1 << n) - 1) : 0);
        default: r = v << n;
      endcase
    end else begin
      c = d[n-1];
      case (mode)
        2'b00:   r = v >> n;
        2'b01:   r = (v >> n) | (d[7] ? (255 & ~(255 >> n)) : 0);
        2'b10:   r = ((v << 8) | v) >> n;
        default: r = (v >> n) | (fill ? (255 & ~(255 >> n)) : 0);
      endcase
    end
    return {c, r[7:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model advanced on the same edges as the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_pending <= 1'b0;
      mdl_left    <= 0;
    end else if (!mdl_pending) begin
      if (cmd_valid) begin
        mdl_pending <= 1'b1;
        mdl_left    <= (cmd_amt == 0) ? 1 : ((cmd_amt > 8) ? 8 : int'(cmd_amt));
        {mdl_carry, mdl_data} <= refShift(cmd_data, int'(cmd_amt), cmd_dir, cmd_mode, cmd_fill);
      end
    end else if (mdl_left > 0) begin
      mdl_left <= mdl_left - 1;
    end else if (res_ready) begin
      mdl_pending <= 1'b0;
    end
  end

  // Cycle-by-cycle comparison of handshake and result outputs with the model.
  always @(negedge clk) begin
    checkOutput("cmd_ready", cmd_ready, !mdl_pending);
    checkOutput("busy", busy, mdl_pending);
    checkOutput("res_valid", res_valid, mdl_pending && (mdl_left == 0));
    if (mdl_pending && (mdl_left == 0)) begin
      checkOutput("res_data", res_data, mdl_data);
      checkOutput("res_carry", res_carry, mdl_carry);
    end
  end

  task automatic waitIdle();
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) seen = 1'b1;
    end
    checkOutput("idle_wait", seen, 1'b1);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input int amt, input bit dir,
                               input logic [1:0] mode, input bit fill);
    cmd_data  = d;
    cmd_amt   = amt[3:0];
    cmd_dir   = dir;
    cmd_mode  = mode;
    cmd_fill  = fill;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Counts edges after acceptance until res_valid is seen (bounded).
  task automatic waitResult(output int lat);
    bit got = 1'b0;
    lat = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (res_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic runDirected(input string name, input logic [7:0] d, input int amt, input bit dir,
                             input logic [1:0] mode, input bit fill,
                             input logic [7:0] expData, input bit expCarry, input int expLat);
    int lat;
    waitIdle();
    applyStimulus(d, amt, dir, mode, fill);
    waitResult(lat);
    checkOutput({name, "_lat"}, lat, expLat);
    checkOutput({name, "_data"}, res_data, expData);
    checkOutput({name, "_carry"}, res_carry, expCarry);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic runBackpressure();
    int lat;
    logic [7:0] heldData;
    logic heldCarry;
    waitIdle();
    applyStimulus(8'h96, 5, 1'b0, 2'b10, 1'b0);
    waitResult(lat);
    checkOutput("bp_lat", lat, 5);
    heldData  = res_data;
    heldCarry = res_carry;
    checkOutput("bp_data", heldData, 8'hD2);
    checkOutput("bp_carry", heldCarry, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      cmd_valid = ~cmd_valid;
      cmd_data  = 8'($urandom);
      cmd_amt   = 4'($urandom);
      @(negedge clk);
      checkOutput("bp_hold_data", res_data, heldData);
      checkOutput("bp_hold_carry", res_carry, heldCarry);
      checkOutput("bp_ready_low", cmd_ready, 1'b0);
      checkOutput("bp_valid_high", res_valid, 1'b1);
    end
    @(posedge clk);
    #1;
    cmd_data  = 8'h81;
    cmd_amt   = 4'd1;
    cmd_dir   = 1'b1;
    cmd_mode  = 2'b01;
    cmd_fill  = 1'b0;
    cmd_valid = 1'b1;
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_ready_after", cmd_ready, 1'b1);
    checkOutput("bp_valid_after", res_valid, 1'b0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    waitResult(lat);
    checkOutput("b2b_lat", lat, 1);
    checkOutput("b2b_data", res_data, 8'hC0);
    checkOutput("b2b_carry", res_carry, 1'b1);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic runResetMidOp();
    waitIdle();
    applyStimulus(8'hF3, 6, 1'b0, 2'b00, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", res_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_data", res_data, 8'h00);
    checkOutput("rst_carry", res_carry, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("rst_after_ready", cmd_ready, 1'b1);
      checkOutput("rst_after_valid", res_valid, 1'b0);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Pin the model with hand-computed results.
    checkOutput("model_ll", refShift(8'hAA, 3, 1'b0, 2'b00, 1'b0), {1'b1, 8'h50});
    checkOutput("model_ar", refShift(8'hCD, 2, 1'b1, 2'b01, 1'b0), {1'b0, 8'hF3});
    checkOutput("model_rr", refShift(8'hCD, 4, 1'b1, 2'b10, 1'b0), {1'b1, 8'hDC});
    checkOutput("model_rl8", refShift(8'hCD, 8, 1'b0, 2'b10, 1'b0), {1'b1, 8'hCD});
    checkOutput("model_fr", refShift(8'h00, 2, 1'b1, 2'b11, 1'b1), {1'b0, 8'hC0});

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", cmd_ready, 1'b1);
    checkOutput("reset_valid", res_valid, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_data", res_data, 8'h00);
    checkOutput("reset_carry", res_carry, 1'b0);
    rst_n = 1'b1;

    runDirected("log_left", 8'b10101010, 3, 1'b0, 2'b00, 1'b0, 8'b01010000, 1'b1, 3);
    runDirected("arith_right", 8'b11001101, 2, 1'b1, 2'b01, 1'b0, 8'b11110011, 1'b0, 2);
    runDirected("rot_right", 8'b11001101, 4, 1'b1, 2'b10, 1'b0, 8'b11011100, 1'b1, 4);
    runDirected("fill_left", 8'h00, 3, 1'b0, 2'b11, 1'b1, 8'h07, 1'b0, 3);
    runDirected("amt_zero", 8'h5A, 0, 1'b0, 2'b00, 1'b0, 8'h5A, 1'b0, 1);
    runDirected("amt_clamp", 8'hFF, 12, 1'b1, 2'b00, 1'b0, 8'h00, 1'b1, 8);
    runDirected("arith_left", 8'hC1, 2, 1'b0, 2'b01, 1'b0, 8'h04, 1'b1, 2);
    runBackpressure();
    runResetMidOp();

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 2500; i++) begin
      @(posedge clk);
      #1;
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_data  = 8'($urandom);
      cmd_amt   = 4'($urandom);
      cmd_dir   = 1'($urandom);
      cmd_mode  = 2'($urandom);
      cmd_fill  = 1'($urandom);
      res_ready = 1'($urandom);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
